// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard/forwarding unit of the in-order pipeline.
package hazard_pkg;

  // Default configuration of the pipeline.
  localparam int AW_DEF         = 5;
  localparam int DEPTH_DEF      = 3;
  localparam int LOAD_READY_DEF = 2;
  localparam int MC_LAT_DEF     = 4;

  // Widest register address a slot can hold; AW must not exceed this.
  localparam int RD_MAX = 8;

  // Forward code meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  // One in-flight writer tracked by the scoreboard.
  typedef struct packed {
    logic              valid;
    logic [RD_MAX-1:0] rd;
    logic              we;
    logic              load;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '{valid: 1'b0, rd: {RD_MAX{1'b0}}, we: 1'b0, load: 1'b0};

  // A slot writes register r when it is live, writing, targets r, and r is not the zero register.
  function automatic logic slot_writes(input slot_t s, input logic [RD_MAX-1:0] r);
    return s.valid & s.we & (s.rd == r) & (r != {RD_MAX{1'b0}});
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-first priority encoder: finds the closest in-flight writer of one source register.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LOAD_READY = LOAD_READY_DEF,
  parameter int FW         = $clog2(DEPTH)
) (
  input  logic [AW-1:0]            src_i,
  input  logic                     used_i,
  // Slots 1..DEPTH-1; the retiring slot never matches and is not presented.
  input  slot_t [DEPTH-2:0]        slots_i,
  output logic                     hit_o,
  output logic                     load_early_o,
  output logic [FW-1:0]            code_o
);

  logic [RD_MAX-1:0] src_ext_s;
  logic              hit_s;
  logic              early_s;
  logic [FW-1:0]     code_s;

  assign src_ext_s = RD_MAX'(src_i);

  // Scan oldest to youngest so the youngest (lowest slot index) match is the one left standing.
  always_comb begin
    hit_s   = 1'b0;
    early_s = 1'b0;
    code_s  = FW'(FWD_RF);
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (used_i && slot_writes(slots_i[k-1], src_ext_s)) begin
        hit_s   = 1'b1;
        early_s = slots_i[k-1].load && (k < LOAD_READY);
        code_s  = FW'(k);
      end else begin
        hit_s   = hit_s;
      end
    end
  end

  assign hit_o        = hit_s;
  assign load_early_o = early_s;
  assign code_o       = code_s;

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: in-flight writer scoreboard, load-use and multi-cycle stalls,
// and registered operand-forwarding selects for the EX stage.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int AW         = AW_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int LOAD_READY = LOAD_READY_DEF,
  parameter int MC_LAT     = MC_LAT_DEF,
  parameter int FW         = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  input  logic          id_rs_used_i,
  input  logic          id_rt_used_i,
  input  logic [AW-1:0] id_rd_i,
  input  logic          id_we_i,
  input  logic          id_load_i,
  input  logic          id_multi_i,
  input  logic          flush_i,
  output logic          stall_o,
  output logic          issue_o,
  output logic [FW-1:0] fwd_a_o,
  output logic [FW-1:0] fwd_b_o,
  output logic          mc_busy_o
);

  localparam int CW = $clog2(MC_LAT) + 1;

  // Slots 1..DEPTH-1 (index 0 = EX). The writer in slot DEPTH retires this cycle and the
  // register file already returns its value, so it can never be a hazard and is not stored.
  slot_t [DEPTH-2:0] slots_r;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_next_s;
  logic              mc_busy_r;
  logic [FW-1:0]     fwd_a_r;
  logic [FW-1:0]     fwd_b_r;

  logic              hit_a_s;
  logic              hit_b_s;
  logic              early_a_s;
  logic              early_b_s;
  logic [FW-1:0]     code_a_s;
  logic [FW-1:0]     code_b_s;
  logic              load_use_s;
  logic              stall_s;
  logic              issue_s;
  slot_t             new_slot_s;

  hazard_match #(
    .AW         (AW),
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .FW         (FW)
  ) u_match_rs (
    .src_i        (id_rs_i),
    .used_i       (id_rs_used_i),
    .slots_i      (slots_r),
    .hit_o        (hit_a_s),
    .load_early_o (early_a_s),
    .code_o       (code_a_s)
  );

  hazard_match #(
    .AW         (AW),
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY),
    .FW         (FW)
  ) u_match_rt (
    .src_i        (id_rt_i),
    .used_i       (id_rt_used_i),
    .slots_i      (slots_r),
    .hit_o        (hit_b_s),
    .load_early_o (early_b_s),
    .code_o       (code_b_s)
  );

  // Stall/issue decision: busy EX always stalls; load-use only matters with a real instruction; flush wins.
  always_comb begin
    load_use_s = id_valid_i & (early_a_s | early_b_s);
    stall_s    = mc_busy_r | load_use_s;
    issue_s    = id_valid_i & ~stall_s & ~flush_i;
  end

  // Record entering EX: the issued instruction, or a bubble when nothing issues.
  always_comb begin
    if (issue_s) begin
      new_slot_s = '{valid: 1'b1, rd: RD_MAX'(id_rd_i), we: id_we_i, load: id_load_i};
    end else begin
      new_slot_s = SLOT_BUBBLE;
    end
  end

  // Multi-cycle countdown: loads on a multi-cycle issue, otherwise counts down to zero and rests.
  always_comb begin
    if (issue_s && id_multi_i) begin
      cnt_next_s = CW'(MC_LAT - 1);
    end else if (cnt_r != {CW{1'b0}}) begin
      cnt_next_s = cnt_r - CW'(1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Scoreboard shift: a busy EX keeps its op and lets a bubble in behind it; otherwise everything advances.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < DEPTH - 1; k++) begin
        slots_r[k] <= SLOT_BUBBLE;
      end
    end else if (mc_busy_r) begin
      slots_r[0] <= slots_r[0];
      if (DEPTH > 2) begin
        slots_r[DEPTH > 2 ? 1 : 0] <= SLOT_BUBBLE;
      end
      for (int k = 2; k < DEPTH - 1; k++) begin
        slots_r[k] <= slots_r[k-1];
      end
    end else begin
      slots_r[0] <= new_slot_s;
      for (int k = 1; k < DEPTH - 1; k++) begin
        slots_r[k] <= slots_r[k-1];
      end
    end
  end

  // Multi-cycle counter and its busy flag, both registered so mc_busy_o comes straight from a flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r     <= {CW{1'b0}};
      mc_busy_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_next_s;
      mc_busy_r <= (cnt_next_s != {CW{1'b0}});
    end
  end

  // Forward selects travel with the ID/EX register: only an issued instruction carries codes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_a_r <= FW'(FWD_RF);
      fwd_b_r <= FW'(FWD_RF);
    end else begin
      fwd_a_r <= (issue_s && hit_a_s) ? code_a_s : FW'(FWD_RF);
      fwd_b_r <= (issue_s && hit_b_s) ? code_b_s : FW'(FWD_RF);
    end
  end

  assign stall_o   = stall_s;
  assign issue_o   = issue_s;
  assign fwd_a_o   = fwd_a_r;
  assign fwd_b_o   = fwd_b_r;
  assign mc_busy_o = mc_busy_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios followed by random
// instruction streams, all compared against an instruction-list reference model.
module tb_hazard_scoreboard;

  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int LR    = 2;
  localparam int MC    = 4;
  localparam int FW    = $clog2(DEPTH);

  logic          clk_i;
  logic          rst_ni;
  logic          id_valid_i;
  logic [AW-1:0] id_rs_i;
  logic [AW-1:0] id_rt_i;
  logic          id_rs_used_i;
  logic          id_rt_used_i;
  logic [AW-1:0] id_rd_i;
  logic          id_we_i;
  logic          id_load_i;
  logic          id_multi_i;
  logic          flush_i;
  logic          stall_o;
  logic          issue_o;
  logic [FW-1:0] fwd_a_o;
  logic [FW-1:0] fwd_b_o;
  logic          mc_busy_o;

  hazard_scoreboard #(
    .AW         (AW),
    .DEPTH      (DEPTH),
    .LOAD_READY (LR),
    .MC_LAT     (MC)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_rs_used_i (id_rs_used_i),
    .id_rt_used_i (id_rt_used_i),
    .id_rd_i      (id_rd_i),
    .id_we_i      (id_we_i),
    .id_load_i    (id_load_i),
    .id_multi_i   (id_multi_i),
    .flush_i      (flush_i),
    .stall_o      (stall_o),
    .issue_o      (issue_o),
    .fwd_a_o      (fwd_a_o),
    .fwd_b_o      (fwd_b_o),
    .mc_busy_o    (mc_busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: list of issued instructions with their current pipeline position.
  typedef struct {
    int rd;
    bit we;
    bit load;
    int pos;
  } rec_t;

  rec_t q[$];
  int   m_cnt;
  int   m_fa;
  int   m_fb;
  int   checks;
  int   errors;
  bit   last_stall;
  bit   last_issue;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Closest writer of src that is still ahead of write-back; early = load not yet forwardable.
  function automatic void lookup(input int src, input bit used, output int code, output bit early);
    int best;
    best  = DEPTH;
    code  = 0;
    early = 1'b0;
    if (used && src != 0) begin
      foreach (q[i]) begin
        if (q[i].we && q[i].rd == src && q[i].pos < best) begin
          best  = q[i].pos;
          early = q[i].load && (q[i].pos < LR);
        end
      end
    end
    if (best < DEPTH) code = best;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_cnt = 0;
    m_fa  = 0;
    m_fb  = 0;
  endfunction

  task automatic step(input bit v, input int rs, input int rt, input bit rsu, input bit rtu,
                      input int rd, input bit we, input bit ld, input bit mul, input bit fl);
    int   ca, cb;
    bit   ea, eb, m_busy, m_stall, m_issue;
    rec_t r;
    rec_t nq[$];
    @(negedge clk_i);
    id_valid_i   = v;
    id_rs_i      = AW'(rs);
    id_rt_i      = AW'(rt);
    id_rs_used_i = rsu;
    id_rt_used_i = rtu;
    id_rd_i      = AW'(rd);
    id_we_i      = we;
    id_load_i    = ld;
    id_multi_i   = mul;
    flush_i      = fl;
    #1;
    lookup(rs, rsu, ca, ea);
    lookup(rt, rtu, cb, eb);
    m_busy  = (m_cnt != 0);
    m_stall = m_busy || (v && (ea || eb));
    m_issue = v && !m_stall && !fl;
    chk("stall", stall_o, m_stall);
    chk("issue", issue_o, m_issue);
    last_stall = m_stall;
    last_issue = m_issue;
    @(posedge clk_i);
    #1;
    m_fa = m_issue ? ca : 0;
    m_fb = m_issue ? cb : 0;
    foreach (q[i]) begin
      if (!(m_busy && q[i].pos == 1)) q[i].pos++;
    end
    foreach (q[i]) begin
      if (q[i].pos <= DEPTH) nq.push_back(q[i]);
    end
    q = nq;
    if (m_issue) begin
      r.rd = rd; r.we = we; r.load = ld; r.pos = 1;
      q.push_back(r);
    end
    if (m_issue && mul) m_cnt = MC - 1;
    else if (m_cnt > 0) m_cnt--;
    chk("fwd_a", fwd_a_o, m_fa);
    chk("fwd_b", fwd_b_o, m_fb);
    chk("mc_busy", mc_busy_o, (m_cnt != 0));
  endtask

  task automatic alu(input int rd, input int rs, input int rt);
    step(1'b1, rs, rt, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();
    rst_ni       = 1'b0;
    id_valid_i   = 1'b1;
    id_rs_i      = '0;
    id_rt_i      = '0;
    id_rs_used_i = 1'b0;
    id_rt_used_i = 1'b0;
    id_rd_i      = '0;
    id_we_i      = 1'b0;
    id_load_i    = 1'b0;
    id_multi_i   = 1'b0;
    flush_i      = 1'b0;
    #2;
    chk("rst_stall", stall_o, 1'b0);
    chk("rst_issue", issue_o, 1'b1);
    chk("rst_busy", mc_busy_o, 1'b0);
    chk("rst_fwd_a", fwd_a_o, 0);
    chk("rst_fwd_b", fwd_b_o, 0);
    @(negedge clk_i);
    id_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Back-to-back ALU dependency forwards from EX.
    alu(3, 1, 2);
    alu(4, 3, 5);
    chk("alu_dep_stall", last_stall, 1'b0);
    chk("alu_dep_fa", fwd_a_o, 1);
    chk("alu_dep_fb", fwd_b_o, 0);
    nops(3);

    // Load-use: one stall cycle, then forward from slot 2 on both operands.
    step(1'b1, 0, 0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_stall", last_stall, 1'b1);
    step(1'b1, 2, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("lu_issue", last_issue, 1'b1);
    chk("lu_fa", fwd_a_o, 2);
    chk("lu_fb", fwd_b_o, 2);
    nops(3);

    // Youngest writer wins; a writer that reached write-back is not forwarded.
    alu(1, 0, 0);
    alu(1, 0, 0);
    alu(6, 1, 0);
    chk("youngest_fa", fwd_a_o, 1);
    nops(3);
    alu(1, 0, 0);
    nops(2);
    alu(6, 1, 0);
    chk("retired_fa", fwd_a_o, 0);
    nops(3);

    // Zero register and unused sources never match.
    alu(0, 1, 2);
    alu(9, 0, 0);
    chk("r0_fa", fwd_a_o, 0);
    alu(7, 1, 2);
    step(1'b1, 7, 7, 1'b0, 1'b0, 11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("unused_stall", last_stall, 1'b0);
    chk("unused_fa", fwd_a_o, 0);
    chk("unused_fb", fwd_b_o, 0);
    nops(3);

    // Multi-cycle op followed by an independent add: three busy cycles, issue on the fourth.
    step(1'b1, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("mul_busy", mc_busy_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      alu(10, 1, 2);
      chk("mul_stall", last_stall, 1'b1);
    end
    alu(10, 1, 2);
    chk("mul_next_issue", last_issue, 1'b1);
    nops(3);

    // Multi-cycle op followed by a dependent add: forwarded from the held EX slot.
    step(1'b1, 0, 0, 1'b0, 1'b0, 7, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) alu(8, 7, 0);
    alu(8, 7, 0);
    chk("mul_dep_issue", last_issue, 1'b1);
    chk("mul_dep_fa", fwd_a_o, 1);
    nops(3);

    // Flush over a pending load-use hazard: nothing issues, a bubble follows.
    step(1'b1, 0, 0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 2, 2, 1'b1, 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("flush_issue", last_issue, 1'b0);
    chk("flush_fa", fwd_a_o, 0);
    nops(3);

    // Reset in the middle of a busy multi-cycle op clears everything at once.
    alu(7, 0, 0);
    step(1'b1, 7, 0, 1'b1, 1'b0, 9, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pre_rst_fa", fwd_a_o, 1);
    @(negedge clk_i);
    id_valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", mc_busy_o, 1'b0);
    chk("mid_rst_stall", stall_o, 1'b0);
    chk("mid_rst_fa", fwd_a_o, 0);
    chk("mid_rst_fb", fwd_b_o, 0);
    model_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Random instruction streams over a small register set to provoke frequent hazards.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 8, $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 3),
           $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding unit for the in-order MIPS pipeline. It tracks up to DEPTH in-flight register writers in a shift-register scoreboard. It generates the decode-stage stall, issue and bubble decisions, and registered forwarding selects for the operand muxes in EX. It extends the existing load-use/forwarding scheme with configurable pipeline depth, configurable load-data readiness, and a stalling multi-cycle execute (mul/div) with held EX slot.

## Interface
Parameters:
- AW, 5, register address width; register 0 is hard-wired zero.
- DEPTH, 3, in-flight slots after decode (slot 1 = EX … slot DEPTH = WB); DEPTH ≥ 2.
- LOAD_READY, 2, minimum slot index (at decode time) from which a load result is forwardable; 1 ≤ LOAD_READY ≤ DEPTH.
- MC_LAT, 4, EX cycles of a multi-cycle op; MC_LAT ≥ 1.
- FW, $clog2(DEPTH), forwarding-code width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- id_valid_i  in  1  instruction present in ID.
- id_rs_i, id_rt_i  in  AW  source addresses.
- id_rs_used_i, id_rt_used_i  in  1  source actually read.
- id_rd_i  in  AW  destination address.
- id_we_i  in  1  instruction writes id_rd_i.
- id_load_i  in  1  instruction is a load.
- id_multi_i  in  1  instruction is a multi-cycle op.
- flush_i  in  1  squash the instruction in ID (taken branch/jump).
- stall_o  out  1  hold PC and IF/ID (combinational).
- issue_o  out  1  ID instruction enters EX this cycle (combinational).
- fwd_a_o, fwd_b_o  out  FW  registered operand select for the instruction in EX: 0 = register file, k = result currently in slot k+1.
- mc_busy_o  out  1  multi-cycle op occupying EX (registered).

## Operation
- Slot record: valid, rd, we, load. Slot "writes r" iff valid & we & rd==r & r!=0.
- Source hazard, evaluated per used source against slots 1..DEPTH-1. Slot DEPTH retires this cycle; the register file writes before it reads, so slot DEPTH never matches. The youngest (lowest k) matching slot wins.
  - Match is a load with k < LOAD_READY → load-use stall.
  - Otherwise the forward code is k.
  - No match, or source unused → code 0.
- stall_o = mc_busy_o | (id_valid_i & load-use stall on either source).
- issue_o = id_valid_i & !stall_o & !flush_i.
- Slot update each cycle:
  - If mc_busy_o: slot 1 holds, slot 2 gets a bubble, and slots 3..DEPTH shift.
  - Otherwise: slot 1 gets the ID instruction if issue_o, else a bubble. Slots k+1 ← k.
- fwd_a_o/fwd_b_o load the computed codes when issue_o, else 0.
- Multi-cycle counter cnt (width $clog2(MC_LAT)+1):
  - Issue with id_multi_i loads cnt = MC_LAT-1.
  - While cnt > 0 it decrements.
  - mc_busy_o = (cnt != 0), registered.
  - MC_LAT = 1 behaves as a plain ALU op.
- A multi-cycle result in slot 1 with cnt = 0 is forwardable like an ALU result.

## Timing
- Reset (async, immediate): all slots invalid, cnt = 0, fwd_a_o = fwd_b_o = 0, mc_busy_o = 0. Hence stall_o = 0, and issue_o follows id_valid_i & !flush_i.
- Forward codes are valid in the cycle after issue and pair with the ID/EX register.
- Load-use stall lasts LOAD_READY-k cycles. With defaults and a back-to-back dependent instruction, this is exactly 1.
- Multi-cycle op: stall_o is high for MC_LAT-1 cycles starting the cycle after issue. The next instruction issues on the MC_LAT-th cycle after.
- flush_i together with stall or hazard: flush wins. issue_o = 0, a bubble is inserted, and cnt is unaffected.
- id_valid_i low: no stall contribution from hazards; the busy stall still applies.
- Reset asserted mid-multi-cycle clears busy in the same cycle. The held instruction is discarded.

## Structure
- Package hazard_pkg holds:
  - slot_t struct (valid, rd, we, load);
  - FWD_RF = 0 constant;
  - parameter defaults.
- Sub-module hazard_match: one source address plus the slot array in, {hit, is_load_early, code} out. It is a youngest-first priority encoder, instantiated once for rs and once for rt.
- Top holds the slot shift register, the counter, and the output registers.

## Test plan
Defaults: DEPTH = 3, LOAD_READY = 2, MC_LAT = 4.
- add r3 then sub r4,r3,r5 back-to-back → stall_o = 0; next cycle fwd_a_o = 1, fwd_b_o = 0.
- lw r2 then add r5,r2,r2 → stall_o = 1 for one cycle, then issue; next cycle fwd_a_o = fwd_b_o = 2.
- add r1; add r1; add r6,r1 → fwd_a_o = 1 (youngest wins). add r1; nop; nop; add r6,r1 → fwd_a_o = 0.
- Write r0, then read r0 → no stall, fwd = 0. Sources marked unused match nothing.
- mul r7 then independent add → mc_busy_o and stall_o high for 3 cycles; add issues on cycle 4. Dependent add r8,r7 then gets fwd_a_o = 1.
- flush_i with a pending load-use hazard → issue_o = 0, bubble inserted. Reset pulse during mul busy → mc_busy_o, stall_o, and fwd codes all 0 immediately.
